// File: rtl/cce_mem_wormhole_client.sv
// Memory-side wormhole endpoint: reassembles command packets, serializes responses back to the requester.
// Define CCE_MEM_CLIENT_CHECK_EN to enable simulation-only protocol checks.
module cce_mem_wormhole_client #(
    parameter int flit_width_p          = 64,
    parameter int cord_width_p          = 8,
    parameter int cid_width_p           = 2,
    parameter int len_width_p           = 4,
    parameter int msg_width_p           = 128,
    parameter int num_outstanding_req_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    input  logic [cid_width_p-1:0]  my_cid_i,
    input  logic [flit_width_p-1:0] cmd_link_data_i,
    input  logic                    cmd_link_v_i,
    output logic                    cmd_link_ready_and_o,
    output logic [msg_width_p-1:0]  mem_cmd_o,
    output logic                    mem_cmd_v_o,
    input  logic                    mem_cmd_yumi_i,
    input  logic [msg_width_p-1:0]  mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic                    mem_resp_ready_o,
    output logic [flit_width_p-1:0] resp_link_data_o,
    output logic                    resp_link_v_o,
    input  logic                    resp_link_ready_and_i
);

    localparam int hdr_w   = 2*cord_width_p + 2*cid_width_p + len_width_p;
    localparam int pkt_w   = hdr_w + msg_width_p;
    localparam int n_flits = (pkt_w + flit_width_p - 1) / flit_width_p;
    localparam int buf_w   = n_flits * flit_width_p;
    localparam int cnt_w   = (n_flits > 1) ? $clog2(n_flits) : 1;
    localparam int ret_w   = cord_width_p + cid_width_p;
    localparam int src_lsb = cord_width_p + cid_width_p + len_width_p;
    localparam int depth   = num_outstanding_req_p;
    localparam int ptr_w   = (depth > 1) ? $clog2(depth) : 1;
    localparam int fcnt_w  = $clog2(depth + 1);

    localparam logic [cnt_w-1:0]       last_cnt = cnt_w'(n_flits - 1);
    localparam logic [len_width_p-1:0] len_val  = len_width_p'(n_flits - 1);
    localparam logic [ptr_w-1:0]       last_ptr = ptr_w'(depth - 1);
    localparam logic [fcnt_w-1:0]      depth_c  = fcnt_w'(depth);

    // ---------------- receive path ----------------
    logic [n_flits-1:0][flit_width_p-1:0] rx_buf_q, rx_buf_d;
    logic [buf_w-1:0]                     rx_pkt_q, rx_pkt_d;
    logic [cnt_w-1:0]                     rx_cnt_q, rx_cnt_d;
    logic                                 rx_full_q, rx_full_d;
    logic                                 rx_accept;

    // ---------------- return-address fifo ----------------
    logic [depth-1:0][ret_w-1:0] fifo_mem_q, fifo_mem_d;
    logic [ptr_w-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [fcnt_w-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ret_w-1:0]            fifo_wdata, fifo_head;

    // ---------------- transmit path ----------------
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    tx_state_e                            tx_state_q, tx_state_d;
    logic [n_flits-1:0][flit_width_p-1:0] tx_buf_q, tx_buf_d;
    logic [cnt_w-1:0]                     tx_cnt_q, tx_cnt_d;
    logic                                 resp_accept;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (fifo_cnt_q == depth_c);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // Outputs are gated by reset so nothing advertises readiness while held in reset.
    assign cmd_link_ready_and_o = reset_n_i & ~rx_full_q & ~fifo_full;
    assign rx_accept            = cmd_link_v_i & cmd_link_ready_and_o;
    assign rx_pkt_q             = rx_buf_q;
    assign rx_pkt_d             = rx_buf_d;
    assign fifo_wdata           = rx_pkt_d[src_lsb +: ret_w];
    assign mem_cmd_o            = rx_pkt_q[hdr_w +: msg_width_p];
    assign mem_cmd_v_o          = rx_full_q;

    always_comb begin
        rx_buf_d  = rx_buf_q;
        rx_cnt_d  = rx_cnt_q;
        rx_full_d = rx_full_q;
        fifo_push = 1'b0;
        if (rx_full_q && mem_cmd_yumi_i) rx_full_d = 1'b0;
        if (rx_accept) begin
            rx_buf_d[rx_cnt_q] = cmd_link_data_i;
            if (rx_cnt_q == last_cnt) begin
                rx_cnt_d  = '0;
                rx_full_d = 1'b1;
                fifo_push = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (fifo_push) begin
            fifo_mem_d[wr_ptr_q] = fifo_wdata;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (fifo_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        fifo_cnt_d = fifo_cnt_q + fcnt_w'(fifo_push) - fcnt_w'(fifo_pop);
    end

    assign mem_resp_ready_o = reset_n_i & (tx_state_q == TX_IDLE) & ~fifo_empty;
    assign resp_accept      = mem_resp_v_i & mem_resp_ready_o;
    assign resp_link_v_o    = (tx_state_q == TX_SEND);
    assign resp_link_data_o = tx_buf_q[tx_cnt_q];

    always_comb begin
        tx_state_d = tx_state_q;
        tx_buf_d   = tx_buf_q;
        tx_cnt_d   = tx_cnt_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (resp_accept) begin
                    // Destination comes from the oldest outstanding command.
                    tx_buf_d   = buf_w'({mem_resp_i, my_cid_i, my_cord_i, len_val, fifo_head});
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (resp_link_ready_and_i) begin
                    if (tx_cnt_q == last_cnt) begin
                        tx_cnt_d   = '0;
                        fifo_pop   = 1'b1;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_buf_q   <= '0;
            rx_cnt_q   <= '0;
            rx_full_q  <= 1'b0;
            fifo_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            tx_state_q <= TX_IDLE;
            tx_buf_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            rx_buf_q   <= rx_buf_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_full_q  <= rx_full_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            tx_state_q <= tx_state_d;
            tx_buf_q   <= tx_buf_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

`ifdef CCE_MEM_CLIENT_CHECK_EN
    logic [10:0] starve_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt_q <= '0;
        end else begin
            if (mem_resp_v_i && fifo_empty) begin
                if (starve_cnt_q != '1) starve_cnt_q <= starve_cnt_q + 1'b1;
            end else begin
                starve_cnt_q <= '0;
            end
            if (starve_cnt_q == 11'd1000)
                $error("mem_resp_v_i held over 1000 cycles with no outstanding command");
            if (rx_accept && rx_cnt_q == '0 &&
                cmd_link_data_i[cord_width_p+cid_width_p +: len_width_p] != len_val)
                $error("command header len field does not match flit count");
            if (mem_cmd_yumi_i && !mem_cmd_v_o)
                $error("mem_cmd_yumi_i asserted without mem_cmd_v_o");
        end
    end
`else
    // Protocol checks compiled out.
`endif

endmodule

// File: tb/tb_cce_mem_wormhole_client.sv
// Scoreboard bench for cce_mem_wormhole_client: stimulus queues expectations, negedge monitors pop and compare.
module tb_cce_mem_wormhole_client;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [7:0]   my_cord_i;
    logic [1:0]   my_cid_i;
    logic [63:0]  cmd_link_data_i;
    logic         cmd_link_v_i;
    logic         cmd_link_ready_and_o;
    logic [127:0] mem_cmd_o;
    logic         mem_cmd_v_o;
    logic         mem_cmd_yumi_i;
    logic [127:0] mem_resp_i;
    logic         mem_resp_v_i;
    logic         mem_resp_ready_o;
    logic [63:0]  resp_link_data_o;
    logic         resp_link_v_o;
    logic         resp_link_ready_and_i;

    always #5 clk_i = ~clk_i;

    cce_mem_wormhole_client dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .my_cord_i            (my_cord_i),
        .my_cid_i             (my_cid_i),
        .cmd_link_data_i      (cmd_link_data_i),
        .cmd_link_v_i         (cmd_link_v_i),
        .cmd_link_ready_and_o (cmd_link_ready_and_o),
        .mem_cmd_o            (mem_cmd_o),
        .mem_cmd_v_o          (mem_cmd_v_o),
        .mem_cmd_yumi_i       (mem_cmd_yumi_i),
        .mem_resp_i           (mem_resp_i),
        .mem_resp_v_i         (mem_resp_v_i),
        .mem_resp_ready_o     (mem_resp_ready_o),
        .resp_link_data_o     (resp_link_data_o),
        .resp_link_v_o        (resp_link_v_o),
        .resp_link_ready_and_i(resp_link_ready_and_i)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_cmd_q[$];
    logic [63:0]  exp_flit_q[$];
    logic [9:0]   ret_q[$];
    bit           yumi_en  = 1'b1;
    int           rdy_mode = 1;
    int           hs_cnt   = 0;
    bit           held_v   = 1'b0;
    logic [63:0]  held;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] pack(input logic [127:0] m, input logic [7:0] dc,
                                          input logic [1:0] di, input logic [7:0] sc,
                                          input logic [1:0] si);
        return {40'd0, m, si, sc, 4'd2, di, dc};
    endfunction

    // Downstream ready: 0 = stalled, 1 = always ready, 2 = toggling each cycle.
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       resp_link_ready_and_i = 1'b0;
            1:       resp_link_ready_and_i = 1'b1;
            default: resp_link_ready_and_i = ~resp_link_ready_and_i;
        endcase
    end

    // Monitor: consumes commands and checks response flits.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            mem_cmd_yumi_i = 1'b0;
            held_v         = 1'b0;
        end else begin
            mem_cmd_yumi_i = 1'b0;
            if (mem_cmd_v_o && yumi_en) begin
                if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
                else chk("mem_cmd_o", mem_cmd_o, exp_cmd_q.pop_front());
                mem_cmd_yumi_i = 1'b1;
            end
            if (resp_link_v_o) begin
                if (held_v) chk("resp_hold_stable", resp_link_data_o, held);
                if (resp_link_ready_and_i) begin
                    hs_cnt++;
                    held_v = 1'b0;
                    if (exp_flit_q.size() == 0) chk("flit_unexpected", 1, 0);
                    else chk("resp_flit", resp_link_data_o, exp_flit_q.pop_front());
                end else begin
                    held_v = 1'b1;
                    held   = resp_link_data_o;
                end
            end
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_flit(input logic [63:0] d);
        int t = 0;
        cmd_link_data_i = d;
        cmd_link_v_i    = 1'b1;
        while (!cmd_link_ready_and_o && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) chk("cmd_ready_timeout", 0, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_link_v_i = 1'b0;
    endtask

    task automatic send_cmd(input logic [127:0] m, input logic [7:0] sc, input logic [1:0] si);
        logic [191:0] p;
        p = pack(m, 8'h10, 2'd0, sc, si);
        exp_cmd_q.push_back(m);
        ret_q.push_back({si, sc});
        for (int k = 0; k < 3; k++) send_flit(p[k*64 +: 64]);
    endtask

    task automatic send_resp_raw(input logic [127:0] m);
        int t = 0;
        mem_resp_i   = m;
        mem_resp_v_i = 1'b1;
        while (!mem_resp_ready_o && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) chk("resp_ready_timeout", 0, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
    endtask

    task automatic send_resp(input logic [127:0] m);
        logic [9:0]   r;
        logic [191:0] p;
        if (ret_q.size() == 0) begin
            chk("resp_without_cmd", 1, 0);
        end else begin
            r = ret_q.pop_front();
            p = pack(m, r[7:0], r[9:8], 8'hFF, 2'd0);
            for (int k = 0; k < 3; k++) exp_flit_q.push_back(p[k*64 +: 64]);
        end
        send_resp_raw(m);
    endtask

    task automatic wait_resp_done();
        int t = 0;
        while ((exp_flit_q.size() != 0 || resp_link_v_o) && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) chk("resp_done_timeout", 0, 1);
        @(negedge clk_i);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i       = 1'b0;
        my_cord_i       = 8'hFF;
        my_cid_i        = 2'd0;
        cmd_link_data_i = '0;
        cmd_link_v_i    = 1'b0;
        mem_cmd_yumi_i  = 1'b0;
        mem_resp_i      = '0;
        mem_resp_v_i    = 1'b0;
        resp_link_ready_and_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", cmd_link_ready_and_o, 0);
        chk("rst_resp_ready", mem_resp_ready_o, 0);
        chk("rst_cmd_v", mem_cmd_v_o, 0);
        chk("rst_resp_v", resp_link_v_o, 0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_cmd_ready", cmd_link_ready_and_o, 1);
        chk("post_rst_cmd_v", mem_cmd_v_o, 0);
        chk("post_rst_resp_v", resp_link_v_o, 0);

        // Response offered with no outstanding command must not be taken.
        mem_resp_i   = 128'hDEAD;
        mem_resp_v_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            chk("early_resp_ready", mem_resp_ready_o, 0);
        end
        mem_resp_v_i = 1'b0;
        @(negedge clk_i);

        // Single command packet.
        send_cmd(128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A501, 8'h03, 2'b01);
        chk("cmd_v_after_last_flit", mem_cmd_v_o, 1);
        chk("cmd_ready_while_holding", cmd_link_ready_and_o, 0);
        repeat (2) @(negedge clk_i);
        chk("cmd_consumed", exp_cmd_q.size(), 0);

        // Reply with hand-computed header flits.
        void'(ret_q.pop_front());
        exp_flit_q.push_back(64'h0000_0012_343F_C903);
        exp_flit_q.push_back(64'h0);
        exp_flit_q.push_back(64'h0);
        hs_cnt = 0;
        send_resp_raw(128'h1234);
        wait_resp_done();
        chk("reply_handshakes", hs_cnt, 3);
        mem_resp_v_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("fifo_empty_after_reply", mem_resp_ready_o, 0);
        end
        mem_resp_v_i = 1'b0;

        // Backpressure on the response link.
        send_cmd(128'h0BAD_F00D_0000_1111_2222_3333_4444_5555, 8'h21, 2'd2);
        rdy_mode = 2;
        hs_cnt   = 0;
        send_resp(128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);
        wait_resp_done();
        chk("backpressure_handshakes", hs_cnt, 3);
        rdy_mode = 1;

        // Fill the return FIFO, then a 9th command stalls until one reply finishes.
        for (int i = 0; i < 8; i++)
            send_cmd({32'hC0DE_0000 + i, 96'h0123_4567_89AB_CDEF_0000_0000 + i}, 8'h40 + 8'(i), 2'(i));
        repeat (4) @(negedge clk_i);
        chk("fifo_full_ready_low", cmd_link_ready_and_o, 0);
        fork
            send_cmd(128'h9999_0000_0000_0000_0000_0000_0000_0009, 8'h99, 2'd3);
            begin
                repeat (6) @(negedge clk_i);
                chk("ninth_stalled", cmd_link_ready_and_o, 0);
                chk("ninth_not_delivered", exp_cmd_q.size(), 1);
                send_resp(128'h5000);
            end
        join
        wait_resp_done();
        for (int i = 1; i < 9; i++) begin
            send_resp(128'h5000 + i);
            wait_resp_done();
        end
        chk("fill_drained_cmds", exp_cmd_q.size(), 0);

        // Reset in the middle of a packet while a response is stalled.
        send_cmd(128'hAAAA_0000_0000_0000_0000_0000_0000_0001, 8'h55, 2'd3);
        rdy_mode = 0;
        send_resp(128'hBBBB);
        repeat (2) @(negedge clk_i);
        send_flit(64'h0000_0000_0000_0810);
        send_flit(64'h0000_0000_0000_0000);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("midrst_resp_v", resp_link_v_o, 0);
        chk("midrst_cmd_v", mem_cmd_v_o, 0);
        chk("midrst_cmd_ready", cmd_link_ready_and_o, 0);
        chk("midrst_resp_ready", mem_resp_ready_o, 0);
        exp_flit_q.delete();
        exp_cmd_q.delete();
        ret_q.delete();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        rdy_mode  = 1;
        @(negedge clk_i);
        send_cmd(128'hCCCC_DDDD_EEEE_FFFF_1111_2222_3333_4444, 8'h66, 2'd2);
        repeat (2) @(negedge clk_i);
        chk("post_midrst_cmd", exp_cmd_q.size(), 0);
        send_resp(128'h7777_8888);
        wait_resp_done();
        chk("final_flits_drained", exp_flit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cce_mem_wormhole_client.md
Name: cce_mem_wormhole_client

Overview:
- Memory-side endpoint of the wormhole-routed memory network.
- Reassembles command packets arriving on a ready-and link into whole memory command messages for a memory model or controller.
- Serializes that controller's response messages back onto the response link, routing each response to the node that sent the matching command.

Parameters:
- flit_width_p, 64: link flit width in bits.
- cord_width_p, 8: coordinate field width.
- cid_width_p, 2: concentrator id field width.
- len_width_p, 4: packet length field width.
- msg_width_p, 128: memory message width (header plus data), identical for cmd and resp.
- num_outstanding_req_p, 8: depth of the return-address FIFO.

Ports:
- clk_i  in  1  sole clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- my_cord_i  in  cord_width_p  this node's coordinate, placed in response src field.
- my_cid_i  in  cid_width_p  this node's cid, placed in response src field.
- cmd_link_data_i  in  flit_width_p  incoming command flit.
- cmd_link_v_i  in  1  flit valid.
- cmd_link_ready_and_o  out  1  flit accepted when v & ready.
- mem_cmd_o  out  msg_width_p  reassembled command.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_yumi_i  in  1  consumer takes command; legal only while v high.
- mem_resp_i  in  msg_width_p  response message.
- mem_resp_v_i  in  1  response valid.
- mem_resp_ready_o  out  1  response accepted when v & ready.
- resp_link_data_o  out  flit_width_p  outgoing response flit.
- resp_link_v_o  out  1  flit valid.
- resp_link_ready_and_i  in  1  downstream accepts flit.

Behaviour:
- Packet layout, LSB first:
  - dst_cord[cord]
  - dst_cid[cid]
  - len[len_width]
  - src_cord[cord]
  - src_cid[cid]
  - msg[msg_width]
  - zero pad to a flit multiple.
- Flit count N = ceil((2*cord+2*cid+len+msg)/flit). len field = N-1. Flit 0 carries bits [flit-1:0]; flit k carries the next slice.
- Reset (reset_n_i low, asynchronous) clears all counters, the FIFO and all valids. All v/ready outputs read 0 during reset.
- Receive path:
  - cmd_link_ready_and_o = receiver not holding a complete message AND return FIFO not full.
  - Each accepted flit is stored at slice index count; count increments per flit.
  - On accepting flit N-1: count clears, message becomes complete, {src_cid, src_cord} is pushed into the return FIFO.
  - mem_cmd_v_o rises the cycle after the last flit is accepted. It holds with stable data until mem_cmd_yumi_i.
  - Receiver is ready again the cycle after yumi; no bypass.
- Transmit path:
  - mem_resp_ready_o = serializer idle AND return FIFO not empty. A response never leaves without a known destination.
  - On accept, the serializer captures the message. It builds the header: dst = FIFO head, src = my_cord_i/my_cid_i, len = N-1.
  - resp_link_v_o rises the next cycle. Flit k is presented until resp_link_ready_and_i, then k advances.
  - After flit N-1 is accepted: FIFO pops, serializer returns to idle, and may accept a new response the following cycle.
- Responses are returned in command-arrival order; the FIFO is strictly in-order.
- Simultaneous FIFO push and pop is allowed, including when full or at count 1.
- FIFO wrap-around is transparent.
- Receive and transmit paths run fully concurrently.
- Incoming len field is ignored functionally; N is fixed by parameters.

Optional Feature:
- CCE_MEM_CLIENT_CHECK_EN defined: simulation-only checks issue $error on:
  - incoming header flit whose len field is not N-1;
  - mem_cmd_yumi_i while mem_cmd_v_o is low;
  - mem_resp_v_i held more than 1000 cycles while the FIFO is empty.
- Not defined: no checks; identical synthesized logic.

Test Plan:
- Defaults (N=3), one command packet:
  - Stimulus: flits carry msg=128'hA5..01, src_cord=8'h03, src_cid=2'b01.
  - Response: mem_cmd_v_o high the cycle after the 3rd flit; mem_cmd_o=128'hA5..01; return FIFO count 1.
- Reply to that command:
  - Stimulus: mem_resp_i=128'h1234 with my_cord_i=8'hFF, my_cid_i=0.
  - Response: 3 flits; flit0 [7:0]=8'h03, cid=1, len=2, src_cord=8'hFF; FIFO empty afterwards.
- Backpressure:
  - Stimulus: resp_link_ready_and_i toggled 1/0 each cycle.
  - Response: each flit held stable while not accepted; exactly 3 handshakes.
- Fill FIFO:
  - Stimulus: 8 commands with no responses.
  - Response: cmd_link_ready_and_o low once the FIFO is full; a 9th packet stalls until one response completes.
- Response before any command:
  - Stimulus: mem_resp_v_i asserted with an empty FIFO.
  - Response: mem_resp_ready_o stays 0.
- Reset mid-packet:
  - Stimulus: assert reset_n_i low after flit 1 of 3.
  - Response: all valids clear immediately; the next full packet reassembles correctly.
